// File: rtl/decode_issue_ctrl_if.sv
// Decode-to-issue handshake bundle: decode/EXE side signals in, issue and mul/div status out.
interface decode_issue_ctrl_if;
  logic        de_valid;
  logic [31:0] de_inst;
  logic        exe_allowin;
  logic        exe_load_valid;
  logic [4:0]  exe_load_dest;
  logic        flush;
  logic        de_allowin;
  logic        issue_valid;
  logic [3:0]  issue_class;
  logic [4:0]  issue_wdest;
  logic        issue_we;
  logic [1:0]  md_op;
  logic        md_busy;
  logic        md_done;

  modport master (
    output de_valid, de_inst, exe_allowin, exe_load_valid, exe_load_dest, flush,
    input  de_allowin, issue_valid, issue_class, issue_wdest, issue_we, md_op, md_busy, md_done
  );

  modport slave (
    input  de_valid, de_inst, exe_allowin, exe_load_valid, exe_load_dest, flush,
    output de_allowin, issue_valid, issue_class, issue_wdest, issue_we, md_op, md_busy, md_done
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Registered decode/issue stage: classifies MIPS32 instructions, picks the write destination,
// interlocks load-use hazards and sequences the multi-cycle HI/LO unit; flush kills issue and mul/div.
module decode_issue_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input logic              clk,
  input logic              reset,
  decode_issue_ctrl_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       cls_md, cls_br, cls_mem, wr_rd, wr_rt, wr_31, rs_used, rt_used, md_start;
  logic [4:0] wdest;
  logic       load_stall, md_stall, fire, take;

  md_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] md_op_q, md_op_d;
  logic       md_busy_q, md_busy_d, md_done_q, md_done_d;
  logic       issue_valid_q, issue_valid_d, issue_we_q, issue_we_d;
  logic [3:0] issue_class_q, issue_class_d;
  logic [4:0] issue_wdest_q, issue_wdest_d;

  assign op    = io.de_inst[31:26];
  assign rs    = io.de_inst[25:21];
  assign rt    = io.de_inst[20:16];
  assign rd    = io.de_inst[15:11];
  assign funct = io.de_inst[5:0];

  always_comb begin
    cls_md = 1'b0; cls_br = 1'b0; cls_mem = 1'b0;
    wr_rd = 1'b0; wr_rt = 1'b0; wr_31 = 1'b0;
    rs_used = 1'b1; rt_used = 1'b0; md_start = 1'b0;
    case (op)
      6'h00: begin
        rt_used = 1'b1;
        case (funct)
          6'h00, 6'h02, 6'h03: begin wr_rd = 1'b1; rs_used = 1'b0; end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: wr_rd = 1'b1;
          6'h08: cls_br = 1'b1;
          6'h09: begin cls_br = 1'b1; wr_rd = 1'b1; end
          6'h10, 6'h12: begin cls_md = 1'b1; wr_rd = 1'b1; rs_used = 1'b0; end
          6'h11, 6'h13: cls_md = 1'b1;
          6'h18, 6'h19, 6'h1a, 6'h1b: begin cls_md = 1'b1; md_start = 1'b1; end
          default: ;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: cls_br = 1'b1;
          5'h10, 5'h11: begin cls_br = 1'b1; wr_31 = 1'b1; end
          default: ;
        endcase
      end
      6'h02: begin cls_br = 1'b1; rs_used = 1'b0; end
      6'h03: begin cls_br = 1'b1; rs_used = 1'b0; wr_31 = 1'b1; end
      6'h04, 6'h05: begin cls_br = 1'b1; rt_used = 1'b1; end
      6'h06, 6'h07: cls_br = 1'b1;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: wr_rt = 1'b1;
      6'h0f: begin wr_rt = 1'b1; rs_used = 1'b0; end
      6'h10: begin
        if (io.de_inst == 32'h4200_0018) begin
          cls_br = 1'b1; rs_used = 1'b0;
        end else if (rs == 5'h00) begin
          wr_rt = 1'b1; rs_used = 1'b0;
        end else if (rs == 5'h04) begin
          rt_used = 1'b1;
        end
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin cls_mem = 1'b1; wr_rt = 1'b1; end
      6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: begin cls_mem = 1'b1; rt_used = 1'b1; end
      default: ;
    endcase
  end

  // Non-writers resolve to $0, so the write enable falls out of the destination.
  assign wdest = wr_rd ? rd : wr_rt ? rt : wr_31 ? 5'd31 : 5'd0;

  assign load_stall = io.de_valid & io.exe_load_valid & (io.exe_load_dest != 5'd0) &
                      ((rs_used & (rs == io.exe_load_dest)) | (rt_used & (rt == io.exe_load_dest)));
  assign md_stall   = io.de_valid & cls_md & (state_q != IDLE);
  assign take       = ~issue_valid_q | io.exe_allowin;
  assign io.de_allowin = ~load_stall & ~md_stall & take & ~io.flush;
  assign fire       = io.de_valid & io.de_allowin;

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_class_d = issue_class_q;
    issue_wdest_d = issue_wdest_q;
    issue_we_d    = issue_we_q;
    if (io.flush) begin
      issue_valid_d = 1'b0;
    end else if (take) begin
      issue_valid_d = fire;
      if (fire) begin
        issue_class_d = {cls_md, cls_br, cls_mem, ~(cls_md | cls_br | cls_mem)};
        issue_wdest_d = wdest;
        issue_we_d    = (wdest != 5'd0);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    if (io.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (fire && md_start) begin
          state_d = BUSY;
          md_op_d = funct[1:0];
          cnt_d   = funct[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        end
        BUSY: if (cnt_q == '0) state_d = DONE;
              else             cnt_d   = cnt_q - CNT_W'(1);
        default: state_d = IDLE;
      endcase
    end
    md_busy_d = (state_d != IDLE);
    md_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      md_op_q       <= 2'b00;
      md_busy_q     <= 1'b0;
      md_done_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_class_q <= 4'b0;
      issue_wdest_q <= 5'd0;
      issue_we_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      md_op_q       <= md_op_d;
      md_busy_q     <= md_busy_d;
      md_done_q     <= md_done_d;
      issue_valid_q <= issue_valid_d;
      issue_class_q <= issue_class_d;
      issue_wdest_q <= issue_wdest_d;
      issue_we_q    <= issue_we_d;
    end
  end

  assign io.issue_valid = issue_valid_q;
  assign io.issue_class = issue_class_q;
  assign io.issue_wdest = issue_wdest_q;
  assign io.issue_we    = issue_we_q;
  assign io.md_op       = md_op_q;
  assign io.md_busy     = md_busy_q;
  assign io.md_done     = md_done_q;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: hazards, mul/div sequencing, flush, destinations, backpressure.
module tb_decode_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  decode_issue_ctrl_if io_if ();

  decode_issue_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [10:0] issue_vec();
    return {io_if.issue_valid, io_if.issue_class, io_if.issue_wdest, io_if.issue_we};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp_v;
    reset = 1'b1;
    io_if.de_valid = 1'b0; io_if.de_inst = 32'h0; io_if.exe_allowin = 1'b1;
    io_if.exe_load_valid = 1'b0; io_if.exe_load_dest = 5'd0; io_if.flush = 1'b0;
    repeat (2) next();
    chk_cnt++;
    if ({issue_vec(), io_if.md_op, io_if.md_busy, io_if.md_done} !== 15'd0)
      $display("FAIL reset_state: got %h expected 0", {issue_vec(), io_if.md_op, io_if.md_busy, io_if.md_done});
    else pass_cnt++;
    reset = 1'b0;
    io_if.de_inst = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
    io_if.de_valid = 1'b1;
    next();
    io_if.de_valid = 1'b0;
    repeat (3) next();
    chk_cnt++;
    if ({io_if.md_busy, io_if.md_op} !== 3'b110)
      $display("FAIL div_started: got %b expected 110", {io_if.md_busy, io_if.md_op});
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({issue_vec(), io_if.md_op, io_if.md_busy, io_if.md_done} !== 15'd0)
      $display("FAIL reset_mid_div: got %h expected 0", {issue_vec(), io_if.md_op, io_if.md_busy, io_if.md_done});
    else pass_cnt++;
    next();
    reset = 1'b0;
    io_if.de_inst = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    io_if.de_valid = 1'b1;
    next();
    io_if.de_valid = 1'b0;
    exp_v = {1'b1, 4'b0001, 5'd3, 1'b1};
    chk_cnt++;
    if (issue_vec() !== exp_v) $display("FAIL addu_after_reset: got %h expected %h", issue_vec(), exp_v);
    else pass_cnt++;
    chk_cnt++;
    if (io_if.md_busy !== 1'b0) $display("FAIL busy_after_reset: got %b expected 0", io_if.md_busy);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    io_if.exe_load_valid = 1'b1; io_if.exe_load_dest = 5'd5;
    io_if.de_inst = rtype(5'd5, 5'd0, 5'd6, 6'h21); io_if.de_valid = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b0) $display("FAIL load_stall_rs: got %b expected 0", io_if.de_allowin);
    else pass_cnt++;
    next();
    chk_cnt++;
    if (io_if.issue_valid !== 1'b0) $display("FAIL load_bubble: got %b expected 0", io_if.issue_valid);
    else pass_cnt++;
    io_if.exe_load_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b1) $display("FAIL load_release: got %b expected 1", io_if.de_allowin);
    else pass_cnt++;
    next();
    chk_cnt++;
    if ({io_if.issue_valid, io_if.issue_wdest} !== {1'b1, 5'd6})
      $display("FAIL load_release_issue: got %h expected %h", {io_if.issue_valid, io_if.issue_wdest}, {1'b1, 5'd6});
    else pass_cnt++;
    io_if.exe_load_valid = 1'b1;
    io_if.de_inst = rtype(5'd0, 5'd5, 5'd6, 6'h21);
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b0) $display("FAIL load_stall_rt: got %b expected 0", io_if.de_allowin);
    else pass_cnt++;
    io_if.de_inst = itype(6'h0f, 5'd5, 5'd5, 16'h1234);
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b1) $display("FAIL lui_no_stall: got %b expected 1", io_if.de_allowin);
    else pass_cnt++;
    io_if.exe_load_dest = 5'd0;
    io_if.de_inst = rtype(5'd0, 5'd0, 5'd6, 6'h21);
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b1) $display("FAIL load_zero_dest: got %b expected 1", io_if.de_allowin);
    else pass_cnt++;
    io_if.exe_load_valid = 1'b0;
    io_if.de_valid = 1'b0;
    next();
  endtask

  task automatic test_div();
    logic [10:0] exp_v;
    io_if.de_inst = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
    io_if.de_valid = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b1) $display("FAIL div_accept: got %b expected 1", io_if.de_allowin);
    else pass_cnt++;
    for (int c = 1; c <= 36; c++) begin
      next();
      if (c == 1) begin
        io_if.de_inst = rtype(5'd0, 5'd0, 5'd7, 6'h10);
        chk_cnt++;
        if (io_if.md_op !== 2'b10) $display("FAIL div_md_op: got %b expected 10", io_if.md_op);
        else pass_cnt++;
      end
      chk_cnt++;
      if (io_if.md_busy !== (c <= 34))
        $display("FAIL div_busy c=%0d: got %b expected %b", c, io_if.md_busy, (c <= 34));
      else pass_cnt++;
      chk_cnt++;
      if (io_if.md_done !== (c == 34))
        $display("FAIL div_done c=%0d: got %b expected %b", c, io_if.md_done, (c == 34));
      else pass_cnt++;
      if (c == 36) begin
        io_if.de_valid = 1'b0;
        exp_v = {1'b1, 4'b1000, 5'd7, 1'b1};
        chk_cnt++;
        if (issue_vec() !== exp_v) $display("FAIL mfhi_issue: got %h expected %h", issue_vec(), exp_v);
        else pass_cnt++;
      end else begin
        @(negedge clk);
        chk_cnt++;
        if (io_if.de_allowin !== (c == 35))
          $display("FAIL mfhi_allowin c=%0d: got %b expected %b", c, io_if.de_allowin, (c == 35));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_mult();
    io_if.de_inst = rtype(5'd1, 5'd2, 5'd0, 6'h18);
    io_if.de_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next();
      if (c == 1) io_if.de_inst = rtype(5'd0, 5'd0, 5'd9, 6'h12);
      chk_cnt++;
      if ({io_if.md_busy, io_if.md_done, io_if.md_op} !== {(c <= 3), (c == 3), 2'b00})
        $display("FAIL mult_state c=%0d: got %b expected %b", c,
                 {io_if.md_busy, io_if.md_done, io_if.md_op}, {(c <= 3), (c == 3), 2'b00});
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (io_if.de_allowin !== (c == 4))
        $display("FAIL mflo_allowin c=%0d: got %b expected %b", c, io_if.de_allowin, (c == 4));
      else pass_cnt++;
    end
    next();
    io_if.de_valid = 1'b0;
    chk_cnt++;
    if (issue_vec() !== {1'b1, 4'b1000, 5'd9, 1'b1})
      $display("FAIL mflo_issue: got %h expected %h", issue_vec(), {1'b1, 4'b1000, 5'd9, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic seen_done;
    io_if.de_inst = rtype(5'd3, 5'd4, 5'd0, 6'h1b);
    io_if.de_valid = 1'b1;
    next();
    io_if.de_valid = 1'b0;
    repeat (8) next();
    io_if.de_inst = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    io_if.de_valid = 1'b1;
    next();
    chk_cnt++;
    if ({io_if.md_busy, io_if.issue_valid} !== 2'b11)
      $display("FAIL busy_before_flush: got %b expected 11", {io_if.md_busy, io_if.issue_valid});
    else pass_cnt++;
    io_if.de_inst = rtype(5'd0, 5'd0, 5'd8, 6'h12);
    io_if.exe_allowin = 1'b0;
    io_if.flush = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b0) $display("FAIL flush_blocks: got %b expected 0", io_if.de_allowin);
    else pass_cnt++;
    next();
    io_if.flush = 1'b0;
    io_if.exe_allowin = 1'b1;
    seen_done = io_if.md_done;
    chk_cnt++;
    if ({io_if.md_busy, io_if.issue_valid} !== 2'b00)
      $display("FAIL flush_kill: got %b expected 00", {io_if.md_busy, io_if.issue_valid});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b1) $display("FAIL mflo_after_flush: got %b expected 1", io_if.de_allowin);
    else pass_cnt++;
    next();
    io_if.de_valid = 1'b0;
    chk_cnt++;
    if (issue_vec() !== {1'b1, 4'b1000, 5'd8, 1'b1})
      $display("FAIL mflo_flush_issue: got %h expected %h", issue_vec(), {1'b1, 4'b1000, 5'd8, 1'b1});
    else pass_cnt++;
    repeat (30) begin
      seen_done = seen_done | io_if.md_done;
      next();
    end
    chk_cnt++;
    if (seen_done !== 1'b0) $display("FAIL no_done_after_flush: got %b expected 0", seen_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [8];
    logic [10:0] exps  [8];
    insts[0] = {6'h03, 26'h0000100};               exps[0] = {1'b1, 4'b0100, 5'd31, 1'b1};
    insts[1] = itype(6'h01, 5'd0, 5'h11, 16'h4);   exps[1] = {1'b1, 4'b0100, 5'd31, 1'b1};
    insts[2] = itype(6'h2b, 5'd5, 5'd4, 16'h0);    exps[2] = {1'b1, 4'b0010, 5'd0, 1'b0};
    insts[3] = itype(6'h09, 5'd1, 5'd0, 16'h1);    exps[3] = {1'b1, 4'b0001, 5'd0, 1'b0};
    insts[4] = itype(6'h23, 5'd1, 5'd9, 16'h4);    exps[4] = {1'b1, 4'b0010, 5'd9, 1'b1};
    insts[5] = rtype(5'd2, 5'd0, 5'd0, 6'h11);     exps[5] = {1'b1, 4'b1000, 5'd0, 1'b0};
    insts[6] = rtype(5'd31, 5'd0, 5'd0, 6'h08);    exps[6] = {1'b1, 4'b0100, 5'd0, 1'b0};
    insts[7] = 32'hfc00_1234;                      exps[7] = {1'b1, 4'b0001, 5'd0, 1'b0};
    io_if.exe_allowin = 1'b1;
    io_if.de_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io_if.de_inst = insts[i];
      next();
      chk_cnt++;
      if (issue_vec() !== exps[i]) $display("FAIL b2b_%0d: got %h expected %h", i, issue_vec(), exps[i]);
      else pass_cnt++;
      if (i == 5) begin
        chk_cnt++;
        if (io_if.md_busy !== 1'b0) $display("FAIL mthi_no_busy: got %b expected 0", io_if.md_busy);
        else pass_cnt++;
      end
    end
    io_if.de_valid = 1'b0;
    next();
  endtask

  task automatic test_backpressure();
    io_if.de_inst = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    io_if.de_valid = 1'b1;
    io_if.exe_allowin = 1'b1;
    next();
    io_if.exe_allowin = 1'b0;
    io_if.de_inst = rtype(5'd1, 5'd2, 5'd10, 6'h25);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (io_if.de_allowin !== 1'b0) $display("FAIL bp_allowin_%0d: got %b expected 0", k, io_if.de_allowin);
      else pass_cnt++;
      next();
      chk_cnt++;
      if (issue_vec() !== {1'b1, 4'b0001, 5'd3, 1'b1})
        $display("FAIL bp_hold_%0d: got %h expected %h", k, issue_vec(), {1'b1, 4'b0001, 5'd3, 1'b1});
      else pass_cnt++;
    end
    io_if.exe_allowin = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (io_if.de_allowin !== 1'b1) $display("FAIL bp_release: got %b expected 1", io_if.de_allowin);
    else pass_cnt++;
    next();
    io_if.de_valid = 1'b0;
    chk_cnt++;
    if (issue_vec() !== {1'b1, 4'b0001, 5'd10, 1'b1})
      $display("FAIL bp_next_issue: got %h expected %h", issue_vec(), {1'b1, 4'b0001, 5'd10, 1'b1});
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_div();
    test_mult();
    test_flush();
    test_back_to_back();
    test_backpressure();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Registered decode/issue stage that replaces purely combinational decoding with a handshaked pipeline register between decode and EXE.
- Classifies each instruction and produces its destination and write-enable.
- Interlocks load-use hazards.
- Sequences the multi-cycle multiply/divide unit through a parametrised busy counter, stalling HI/LO consumers until the result lands.
- Supports flush on exception/ERET commit.

Parameters:
- MUL_CYCLES, 2, cycles mult/multu occupies the HI/LO unit (>=1)
- DIV_CYCLES, 33, cycles div/divu occupies the HI/LO unit (>=1)
- CNT_W, 6, busy-counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- de_valid  in  1  decode holds a valid instruction
- de_inst  in  32  MIPS32 instruction word
- exe_allowin  in  1  EXE accepts a new instruction this cycle
- exe_load_valid  in  1  instruction currently in EXE is a load
- exe_load_dest  in  5  destination register of that load
- flush  in  1  exception/ERET commit; kills the issue register and any in-flight mul/div
- de_allowin  out  1  decode instruction is consumed this cycle
- issue_valid  out  1  issue register holds a valid instruction
- issue_class  out  4  one-hot {muldiv, branch/jump, mem, alu}
- issue_wdest  out  5  destination register
- issue_we  out  1  register-file write enable
- md_op  out  2  00 mult, 01 multu, 10 div, 11 divu (valid while md_busy)
- md_busy  out  1  mul/div unit occupied
- md_done  out  1  one-cycle pulse; HI/LO written this cycle

Behaviour:
- Reset: issue_valid=0, issue_class=0, issue_wdest=0, issue_we=0, md_op=00, md_busy=0, md_done=0, FSM=IDLE, counter=0.
- Classes:
  - muldiv = mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
  - branch = beq/bne/bgez/bgtz/blez/bltz/bgezal/bltzal/j/jal/jr/jalr/eret.
  - mem = all loads/stores.
  - alu = everything else, including unrecognised encodings.
- Destination selection:
  - rd for R-type writers and jalr.
  - rt for I-type ALU, loads and mfc0.
  - 31 for jal, bgezal and bltzal.
  - Otherwise 0.
  - issue_we = writer & (wdest != 0).
- Source use:
  - rs is used by all instructions except j, jal, lui, mfhi, mflo, mfc0, eret, sll, sra, srl.
  - rt is used by R-type, beq, bne, stores and mtc0.
- load_stall = de_valid & exe_load_valid & exe_load_dest!=0 & (exe_load_dest matches a used rs or used rt).
- md_stall = de_valid & (instruction is in the muldiv class) & (FSM != IDLE).
- ready_go = ~load_stall & ~md_stall.
- de_allowin = ready_go & (~issue_valid | exe_allowin) & ~flush.
- fire = de_valid & de_allowin.
- Issue register update:
  - flush: issue_valid<=0.
  - Else if (~issue_valid | exe_allowin): issue_valid<=fire, and the other fields load on fire.
  - Else: hold all fields unchanged (backpressure).
- Mul/div FSM has three states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on fire of mult/multu/div/divu. md_op is latched. The counter loads MUL_CYCLES-1 or DIV_CYCLES-1.
  - BUSY: the counter decrements each cycle. At 0, go to DONE.
  - DONE: md_done=1 for exactly one cycle, then IDLE.
  - md_busy = (FSM != IDLE).
  - A HI/LO consumer is therefore accepted no earlier than the cycle after md_done.
- Latency:
  - First consumer-issue cycle is N+2 after the op issues at cycle 0, where N = MUL_CYCLES or DIV_CYCLES.
  - For N=1: BUSY lasts one cycle, DONE follows, and the op is retired.
- flush during BUSY or DONE: FSM->IDLE, counter->0, no md_done pulse. flush has priority over fire in the same cycle.
- mthi/mtlo issued while IDLE do not enter BUSY.
- Reset mid-operation: everything returns immediately to its reset values.

Test Plan:
- Reset asserted mid-div -> all outputs 0 the next sample; de_inst=addu $3,$1,$2 afterwards, exe_allowin=1 -> issue_valid=1, class=0001, wdest=3, we=1 one cycle later.
- exe_load_valid=1, exe_load_dest=5, de_inst=addu $6,$5,$0 -> de_allowin=0; exe_load_valid drops -> fires next cycle, wdest=6.
- div issued at cycle 0, DIV_CYCLES=33, mfhi waiting in decode -> md_busy=1 cycles 1-34, md_done=1 at cycle 34, mfhi issues at cycle 35, md_op=10.
- flush at cycle 10 of a div -> md_busy=0 next cycle, no md_done, issue_valid=0; a subsequent mflo is not stalled.
- jal then bgezal $0 -> wdest=31, we=1, class=0100; sw $4,0($5) -> we=0, class=0010; addiu $0,$1,1 -> we=0.
- exe_allowin=0 with issue_valid=1 -> de_allowin=0 and all issue fields held stable for 5 cycles; exe_allowin=1 -> next instruction loads.
